// File: rtl/param_report_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : param_report_pkg
//  Purpose  : Shared word-kind encodings, FSM state type and frame constants
//             for the parameter read-back reporter.
//  Revision : 1.0  - initial release
// ============================================================================
package param_report_pkg;

    // Word type tags carried on kind_o alongside each data word.
    localparam logic [1:0] KIND_HDR = 2'd0;
    localparam logic [1:0] KIND_VAL = 2'd1;
    localparam logic [1:0] KIND_SUM = 2'd2;

    // Number of parameter values reported in one frame.
    // The header word carries this count.
    localparam int unsigned NUM_VALUES = 2;

    // Reporter FSM states, with explicit encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_V0   = 3'd2,
        ST_V1   = 3'd3,
        ST_SUM  = 3'd4
    } state_t;

endpackage : param_report_pkg
`default_nettype wire

// File: rtl/param_report_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : param_report_out_reg
//  Purpose  : One-entry output register with valid/ready hold semantics.
//             A load always wins. Otherwise a transfer empties the register
//             and returns data/kind to zero. With no load and no transfer
//             the register holds its contents.
//  Revision : 1.0  - initial release
// ============================================================================
module param_report_out_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_kind,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_kind
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_kind;

    // Load / drain / hold of the single output entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_kind  <= 2'd0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_kind  <= i_kind;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_kind  <= 2'd0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_kind  = r_kind;

endmodule : param_report_out_reg
`default_nettype wire

// File: rtl/param_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : param_reporter
//  Purpose  : Reports the elaborated VALUE_0 / VALUE_1 parameters as a framed
//             word stream (header, values, checksum) over valid/ready.
//             The frame is launched by start_i while idle.
//  Revision : 1.0  - initial release
// ============================================================================
module param_reporter
    import param_report_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned VALUE_0 = 5,
    parameter int unsigned VALUE_1 = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       kind_o,
    output logic             done_o
);

    // Frame contents, truncated to the data width.
    localparam logic [WIDTH-1:0] C_HDR_WORD = WIDTH'(NUM_VALUES);
    localparam logic [WIDTH-1:0] C_VALUE_0  = WIDTH'(VALUE_0);
    localparam logic [WIDTH-1:0] C_VALUE_1  = WIDTH'(VALUE_1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_sum;
    logic             r_done;
    logic             r_busy;

    logic             w_xfer;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic [1:0]       w_load_kind;
    logic             w_acc_clr;
    logic             w_acc_add;
    logic             w_done_next;

    // A word leaves the output register only on a valid/ready handshake.
    assign w_xfer = valid_o && ready_i;

    // The running sum plus the word now transferring.
    // In V1 this forms the checksum word in the same cycle.
    assign w_acc_sum = r_acc + data_o;

    // Output register: holds the current word stable under backpressure.
    param_report_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_kind  (w_load_kind),
        .i_ready (ready_i),
        .o_valid (valid_o),
        .o_data  (data_o),
        .o_kind  (kind_o)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and word sequencing. Each state advances only on a transfer
    // and preloads the following word, so the words run back to back.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_kind  = KIND_HDR;
        w_acc_clr    = 1'b0;
        w_acc_add    = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_HDR;
                    w_load       = 1'b1;
                    w_load_data  = C_HDR_WORD;
                    w_load_kind  = KIND_HDR;
                    w_acc_clr    = 1'b1;
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    w_state_next = ST_V0;
                    w_load       = 1'b1;
                    w_load_data  = C_VALUE_0;
                    w_load_kind  = KIND_VAL;
                    w_acc_add    = 1'b1;
                end
            end
            ST_V0: begin
                if (w_xfer) begin
                    w_state_next = ST_V1;
                    w_load       = 1'b1;
                    w_load_data  = C_VALUE_1;
                    w_load_kind  = KIND_VAL;
                    w_acc_add    = 1'b1;
                end
            end
            ST_V1: begin
                if (w_xfer) begin
                    w_state_next = ST_SUM;
                    w_load       = 1'b1;
                    w_load_data  = w_acc_sum;
                    w_load_kind  = KIND_SUM;
                    w_acc_add    = 1'b1;
                end
            end
            ST_SUM: begin
                if (w_xfer) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Checksum accumulator: cleared on frame start, and summed as the
    // header and value words transfer. Wrap-around is modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst || w_acc_clr) begin
            r_acc <= '0;
        end else if (w_acc_add) begin
            r_acc <= w_acc_sum;
        end
    end

    // Registered status flags: done pulses once after the checksum transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= w_done_next;
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    assign done_o = r_done;
    assign busy_o = r_busy;

endmodule : param_reporter
`default_nettype wire

// File: tb/tb_param_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_reporter
//  Purpose  : Self-checking bench for param_reporter. It runs three
//             parameterisations: default; 32/33; and 8-bit 200/100.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_param_reporter;

    localparam int NDUT = 3;
    localparam int WID[NDUT] = '{32, 32, 8};
    localparam int V0[NDUT]  = '{5, 32, 200};
    localparam int V1[NDUT]  = '{9, 33, 100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [NDUT];
    logic        start_v [NDUT];
    logic        ready_v [NDUT];
    logic        busy_v  [NDUT];
    logic        valid_v [NDUT];
    logic        done_v  [NDUT];
    logic [1:0]  kind_v  [NDUT];
    logic [31:0] data_v  [NDUT];

    logic [31:0] d0_data;
    logic [31:0] d1_data;
    logic [7:0]  d2_data;

    int n_chk = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    param_reporter u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start_i(start_v[0]), .busy_o(busy_v[0]),
        .valid_o(valid_v[0]), .ready_i(ready_v[0]), .data_o(d0_data),
        .kind_o(kind_v[0]), .done_o(done_v[0])
    );

    param_reporter #(.WIDTH(32), .VALUE_0(32), .VALUE_1(33)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start_i(start_v[1]), .busy_o(busy_v[1]),
        .valid_o(valid_v[1]), .ready_i(ready_v[1]), .data_o(d1_data),
        .kind_o(kind_v[1]), .done_o(done_v[1])
    );

    param_reporter #(.WIDTH(8), .VALUE_0(200), .VALUE_1(100)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .start_i(start_v[2]), .busy_o(busy_v[2]),
        .valid_o(valid_v[2]), .ready_i(ready_v[2]), .data_o(d2_data),
        .kind_o(kind_v[2]), .done_o(done_v[2])
    );

    always_comb begin
        data_v[0] = d0_data;
        data_v[1] = d1_data;
        data_v[2] = {24'd0, d2_data};
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut=%0d t=%0t got=%0h want=%0h", nm, d, $time, act, exp);
        end
    endtask

    // Reference frame: header = count, the two values, then their sum
    // with the header, all reduced modulo 2^width. Packed as {kind, data}.
    function automatic logic [33:0] exp_word(input int d, input int p);
        longint unsigned m;
        longint unsigned s;
        m = (64'd1 << WID[d]) - 64'd1;
        s = 64'd2 + longint'(V0[d]) + longint'(V1[d]);
        case (p)
            0:       exp_word = {2'd0, 32'd2};
            1:       exp_word = {2'd1, 32'(longint'(V0[d]) & m)};
            2:       exp_word = {2'd1, 32'(longint'(V1[d]) & m)};
            default: exp_word = {2'd2, 32'(s & m)};
        endcase
    endfunction

    // Behavioural model: position in the 4-word frame (-1 = idle) and a pending done.
    int pos[NDUT]      = '{-1, -1, -1};
    bit exp_done[NDUT] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        logic [33:0] w;
        bit          have;
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                have = (pos[d] >= 0);
                w    = have ? exp_word(d, pos[d]) : 34'd0;
                chk("mon_valid", d, {31'd0, valid_v[d]}, {31'd0, have});
                chk("mon_busy",  d, {31'd0, busy_v[d]},  {31'd0, have});
                chk("mon_done",  d, {31'd0, done_v[d]},  {31'd0, exp_done[d]});
                chk("mon_kind",  d, {30'd0, kind_v[d]},  {30'd0, w[33:32]});
                chk("mon_data",  d, data_v[d], w[31:0]);
                // Advance the model with this cycle's inputs.
                if (rst_v[d]) begin
                    pos[d]      = -1;
                    exp_done[d] = 1'b0;
                end else begin
                    exp_done[d] = 1'b0;
                    if (pos[d] < 0) begin
                        if (start_v[d]) pos[d] = 0;
                    end else if (ready_v[d]) begin
                        if (pos[d] == 3) begin
                            pos[d]      = -1;
                            exp_done[d] = 1'b1;
                        end else begin
                            pos[d] = pos[d] + 1;
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic        ready;
        logic        ev;
        logic        eb;
        logic        ed;
        logic [1:0]  ek;
        logic [31:0] edat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic ev,
                       input logic eb, input logic ed, input logic [1:0] ek, input logic [31:0] edat);
        vec_t v;
        v.rst = r; v.start = s; v.ready = rd; v.ev = ev; v.eb = eb; v.ed = ed; v.ek = ek; v.edat = edat;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on one DUT and check a full frame with ready held high.
    task automatic frame_check(input int d, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        start_v[d] = 1'b1;
        ready_v[d] = 1'b1;
        step();
        start_v[d] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("frm_valid", d, {31'd0, valid_v[d]}, 32'd1);
            chk("frm_kind", d, {30'd0, kind_v[d]}, (k == 0) ? 32'd0 : (k == 3) ? 32'd2 : 32'd1);
            chk("frm_data", d, data_v[d], (k == 0) ? 32'd2 : (k == 1) ? w1 : (k == 2) ? w2 : w3);
            step();
        end
        @(negedge clk);
        chk("frm_done", d, {31'd0, done_v[d]}, 32'd1);
        chk("frm_busy", d, {31'd0, busy_v[d]}, 32'd0);
        step();
        ready_v[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_v[d] = 1'b1; start_v[d] = 1'b0; ready_v[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) rst_v[d] = 1'b0;
        mon_en = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_valid", 0, {31'd0, valid_v[0]}, 32'd0);
        chk("rst_busy",  0, {31'd0, busy_v[0]},  32'd0);
        chk("rst_data",  0, data_v[0], 32'd0);
        step();

        // Basic frame, ready high.
        add(0,1,1, 0,0,0,0,0);  add(0,0,1, 1,1,0,0,2);  add(0,0,1, 1,1,0,1,5);
        add(0,0,1, 1,1,0,1,9);  add(0,0,1, 1,1,0,2,16); add(0,0,1, 0,0,1,0,0);
        add(0,0,0, 0,0,0,0,0);
        // Backpressure on the header for three cycles.
        add(0,1,1, 0,0,0,0,0);  add(0,0,0, 1,1,0,0,2);  add(0,0,0, 1,1,0,0,2);
        add(0,0,0, 1,1,0,0,2);  add(0,0,1, 1,1,0,0,2);  add(0,0,1, 1,1,0,1,5);
        add(0,0,1, 1,1,0,1,9);  add(0,0,1, 1,1,0,2,16); add(0,0,0, 0,0,1,0,0);
        // Reset while V0 is valid, then a fresh frame.
        add(0,1,1, 0,0,0,0,0);  add(0,0,1, 1,1,0,0,2);  add(1,0,0, 1,1,0,1,5);
        add(0,1,0, 0,0,0,0,0);  add(0,0,1, 1,1,0,0,2);  add(0,0,1, 1,1,0,1,5);
        add(0,0,1, 1,1,0,1,9);  add(0,0,1, 1,1,0,2,16); add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_v[0] = tbl[i].rst; start_v[0] = tbl[i].start; ready_v[0] = tbl[i].ready;
            @(negedge clk);
            chk("tbl_valid", 0, {31'd0, valid_v[0]}, {31'd0, tbl[i].ev});
            chk("tbl_busy",  0, {31'd0, busy_v[0]},  {31'd0, tbl[i].eb});
            chk("tbl_done",  0, {31'd0, done_v[0]},  {31'd0, tbl[i].ed});
            chk("tbl_kind",  0, {30'd0, kind_v[0]},  {30'd0, tbl[i].ek});
            chk("tbl_data",  0, data_v[0], tbl[i].edat);
            step();
        end
        rst_v[0] = 1'b0; start_v[0] = 1'b0; ready_v[0] = 1'b0;

        // Overridden parameters and 8-bit checksum wrap.
        frame_check(1, 32'd32, 32'd33, 32'd67);
        frame_check(2, 32'd200, 32'd100, 32'd46);

        // start held high: no restart mid-frame, next header right after done.
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("hold_done",  0, {31'd0, done_v[0]},  32'd1);
        chk("hold_valid", 0, {31'd0, valid_v[0]}, 32'd0);
        step();
        @(negedge clk);
        chk("hold_hdr_valid", 0, {31'd0, valid_v[0]}, 32'd1);
        chk("hold_hdr_data",  0, data_v[0], 32'd2);
        chk("hold_hdr_kind",  0, {30'd0, kind_v[0]}, 32'd0);
        step();
        start_v[0] = 1'b0;
        repeat (6) step();

        // Randomised traffic on all three, checked by the model.
        for (int c = 0; c < 900; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                rst_v[d]   = ($urandom_range(0, 79) == 0);
                start_v[d] = ($urandom_range(0, 3) == 0);
                ready_v[d] = ($urandom_range(0, 2) != 0);
            end
            step();
        end
        for (int d = 0; d < NDUT; d++) begin
            rst_v[d] = 1'b0; start_v[d] = 1'b0; ready_v[d] = 1'b1;
        end
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t got=running want=finished", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_param_reporter
`default_nettype wire

// File: doc/param_reporter.md
Name: param_reporter

Overview:
Read-back counterpart to the hierarchical parameter-override testcases. A leaf module reports its effective elaborated parameter values upward, as a framed word stream over a valid/ready interface. A bench or top module can then check that defparam or #() overrides reached the instance. Sits at the leaf of a proxy hierarchy and is instantiated with overridable VALUE_0/VALUE_1.

Parameters:
WIDTH, 32, data word width in bits (>= 4)
VALUE_0, 5, first reported parameter; truncated to WIDTH bits
VALUE_1, 9, second reported parameter; truncated to WIDTH bits

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start_i  input  1  request one report frame; sampled only in IDLE
busy_o  output  1  high while a frame is in progress (FSM not IDLE)
valid_o  output  1  data_o/kind_o hold a word for transfer
ready_i  input  1  consumer accepts the word; a transfer occurs when valid_o && ready_i
data_o  output  WIDTH  word payload
kind_o  output  2  word type: 0 = header, 1 = value, 2 = checksum; 3 is unused
done_o  output  1  one-cycle pulse after the checksum word transfers

Behaviour:
- Reset (sync, active-high, dominates every other input). Next-cycle state is IDLE. Outputs: valid_o=0, busy_o=0, done_o=0, data_o=0, kind_o=0. The checksum accumulator is cleared.
- FSM states: IDLE, HDR, V0, V1, SUM.
- IDLE: if start_i=1, go to HDR.
- HDR: word = count = 2, kind 0.
- V0: word = VALUE_0[WIDTH-1:0], kind 1.
- V1: word = VALUE_1[WIDTH-1:0], kind 1.
- SUM: word = checksum, kind 2. On transfer, go to IDLE and assert done_o for exactly one cycle.
- Latency: start_i sampled high in IDLE at edge t gives valid_o=1 with the header word from cycle t+1 onward.
- Each of HDR/V0/V1/SUM advances only on a transfer. Back-to-back transfers with ready_i held high give 4 consecutive valid cycles.
- Handshake rules:
  - valid_o=1 exactly in HDR/V0/V1/SUM; it never drops without a transfer, except on reset.
  - data_o and kind_o remain stable while valid_o=1 && ready_i=0.
  - valid_o does not depend combinationally on ready_i; all outputs are registered.
  - While valid_o=0, data_o and kind_o hold 0.
- Checksum: header + VALUE_0 + VALUE_1, summed modulo 2^WIDTH. Accumulated in a registered WIDTH-bit adder as each of the first three words transfers. Wrap-around is silent.
- start_i while busy_o=1 is ignored; there is no queueing.
- start_i in the done_o cycle is accepted, because the FSM is already IDLE. The next header is valid in the following cycle, and the accumulator is cleared on frame start.
- Reset mid-frame aborts the frame. No done_o is produced. The next start_i produces a full fresh frame.
- ready_i is ignored in IDLE.

Decomposition:
- Shared package param_report_pkg holds:
  - kind encodings KIND_HDR=0, KIND_VAL=1, KIND_SUM=2
  - state enum constants
  - NUM_VALUES=2
- One natural sub-module: param_report_out_reg. It is a one-entry output register with valid/ready hold semantics and sync reset.
- The FSM and accumulator stay in param_reporter.

Test Plan:
- Default params, ready_i=1, pulse start_i at cycle 0 -> words (kind,data) (0,2),(1,5),(1,9),(2,16) on cycles 1-4; done_o=1 on cycle 5 only; busy_o=0 on cycle 5.
- Proxy hierarchy with VALUE_0=32, VALUE_1=33 applied via defparam on the leaf instance path -> (0,2),(1,32),(1,33),(2,67).
- Backpressure: ready_i=0 for cycles 1-3 then 1 -> header 2 held stable for 4 cycles with valid_o=1; the remaining words follow; checksum 16 unchanged.
- WIDTH=8, VALUE_0=200, VALUE_1=100 -> (0,2),(1,200),(1,100),(2,46), since 302 mod 256 = 46.
- start_i held high for the entire frame and into the done_o cycle -> the second frame header appears the cycle after done_o; no extra frame is started mid-frame.
- rst=1 for one cycle while V0 is valid -> next cycle valid_o=0, busy_o=0, data_o=0, with no done_o. A subsequent start_i yields the full sequence 2,5,9,16.
